// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the HE multiplier arbiter.
// Contents: FSM state encoding and the watchdog counter width helper.
// BIT_WIDTH normally arrives from he_headers.sv; the guard keeps a
// standalone build of this slice usable.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

package he_mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Watchdog counter width: clog2(TIMEOUT+1), never narrower than 1 bit.
    function automatic int wd_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared multiplier.
// Requester side: req, req_a, req_b -> gnt, rsp_valid, rsp_c, rsp_err.
// Multiplier side: mul_start, mul_a, mul_b -> mul_c, mul_done.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus multiplier).
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

interface mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = `BIT_WIDTH
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0][DW-1:0] req_a;
    logic [NUM_REQ-1:0][DW-1:0] req_b;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [2*DW-1:0]            rsp_c;
    logic                       rsp_err;
    logic                       mul_start;
    logic [DW-1:0]              mul_a;
    logic [DW-1:0]              mul_b;
    logic [2*DW-1:0]            mul_c;
    logic                       mul_done;

    modport slave (
        input  req, req_a, req_b, mul_c, mul_done,
        output gnt, rsp_valid, rsp_c, rsp_err, mul_start, mul_a, mul_b
    );

    modport master (
        output req, req_a, req_b, mul_c, mul_done,
        input  gnt, rsp_valid, rsp_c, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
// Ports: req_i (request vector), ptr_i (highest-priority index),
//        gnt_o (one-hot winner), idx_o (encoded winner), any_o (some request set).
// The search starts at ptr_i and wraps at NUM_REQ; the pointer register
// itself lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one DW x DW multiplier among NUM_REQ requesters (round-robin).
// Ports: clk, rst (async, active-low), bus (mul_arbiter_if.slave: request,
//        grant, response and multiplier handshake), busy (not IDLE).
// Flow: IDLE picks a winner and latches its operands, START pulses gnt and
// mul_start, WAIT collects the product or times out, RESP returns it.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module mul_arbiter
    import he_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = `BIT_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus,
    output logic         busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = wd_cnt_w(TIMEOUT);
    // The count already includes the START cycle, so firing at TIMEOUT-1
    // puts the error response exactly TIMEOUT cycles after mul_start.
    localparam int WD_LAST = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   cur_idx_q, cur_idx_d;
    logic [DW-1:0]   op_a_q, op_a_d;
    logic [DW-1:0]   op_b_q, op_b_d;
    logic [2*DW-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wd_q, wd_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [DW-1:0]      sel_a, sel_b;
    logic [NUM_REQ-1:0] cur_oh;
    logic               wd_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // AND-OR operand select driven by the one-hot pick.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a = sel_a | (bus.req_a[i] & {DW{pick_oh[i]}});
            sel_b = sel_b | (bus.req_b[i] & {DW{pick_oh[i]}});
        end
    end

    assign cur_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx_q;
    assign wd_fire = (TIMEOUT != 0) && (wd_q == CW'(WD_LAST));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_idx_d = cur_idx_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        err_d     = err_q;
        wd_d      = wd_q;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (pick_any) begin
                    cur_idx_d = pick_idx;
                    op_a_d    = sel_a;
                    op_b_d    = sel_b;
                    state_d   = START;
                end
            end
            START: begin
                // mul_done here is deliberately not looked at.
                wd_d    = wd_q + CW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + CW'(1);
                if (bus.mul_done) begin
                    res_d   = bus.mul_c;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_fire) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (cur_idx_q == IW'(NUM_REQ - 1)) ? '0 : cur_idx_q + IW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_idx_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_idx_q <= cur_idx_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_q     <= res_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    assign bus.mul_start = (state_q == START);
    assign bus.mul_a     = op_a_q;
    assign bus.mul_b     = op_b_q;
    assign bus.gnt       = (state_q == START) ? cur_oh : '0;
    assign bus.rsp_valid = (state_q == RESP) ? cur_oh : '0;
    assign bus.rsp_c     = res_q;
    assign bus.rsp_err   = err_q & (state_q == RESP);
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module tb_mul_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    // Behavioural multiplier controls.
    int mul_lat  = 1;
    bit mul_dead = 1'b0;
    bit mul_spur = 1'b0;

    mul_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus();

    mul_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Multiplier: done arrives mul_lat cycles after the start cycle.
    initial begin
        logic [DW-1:0] ma, mb;
        bus.mul_done = 1'b0;
        bus.mul_c    = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start && !mul_dead) begin
                ma = bus.mul_a;
                mb = bus.mul_b;
                if (mul_spur) begin
                    bus.mul_done = 1'b1;
                    bus.mul_c    = 32'hDEAD_BEEF;
                end
                for (int k = 0; k < mul_lat; k++) begin
                    @(posedge clk);
                    #1;
                    bus.mul_done = 1'b0;
                end
                bus.mul_c    = 32'(ma) * 32'(mb);
                bus.mul_done = 1'b1;
                @(posedge clk);
                #1;
                bus.mul_done = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        int              lat;
        bit              dead;
        bit              spur;
        bit              drop_early;
        logic [N-1:0]    exp_gnt;
        logic [2*DW-1:0] exp_c;
        logic            exp_err;
        int              exp_cyc;
    } vec_t;

    vec_t tbl[6];

    // One operation from an IDLE cycle (cycle 0) through its response.
    task automatic run_vec(input int vi, input vec_t v);
        int n;
        bit got_g, got_r, hold_ok, busy_ok;
        for (int k = 0; k < N; k++) begin
            bus.req_a[k] = v.req[k] ? v.a : (16'hE000 | 16'(k));
            bus.req_b[k] = v.req[k] ? v.b : (16'hE100 | 16'(k));
        end
        mul_lat  = v.lat;
        mul_dead = v.dead;
        mul_spur = v.spur;
        bus.req  = v.req;
        n = 0; got_g = 1'b0; got_r = 1'b0; hold_ok = 1'b1; busy_ok = 1'b1;
        while (!got_r && n < 40) begin
            @(negedge clk);
            if (n == 0 && busy) busy_ok = 1'b0;
            if (n >= 1 && !busy) busy_ok = 1'b0;
            if (n >= 1 && (bus.mul_a !== v.a || bus.mul_b !== v.b)) hold_ok = 1'b0;
            if (bus.gnt != '0) begin
                chk($sformatf("v%0d_gnt", vi), bus.gnt, v.exp_gnt);
                chk($sformatf("v%0d_gnt_cycle", vi), n, 1);
                chk($sformatf("v%0d_mul_start", vi), bus.mul_start, 1'b1);
                got_g = 1'b1;
            end
            if (bus.rsp_valid != '0) begin
                chk($sformatf("v%0d_rsp_valid", vi), bus.rsp_valid, v.exp_gnt);
                chk($sformatf("v%0d_rsp_c", vi), bus.rsp_c, v.exp_c);
                chk($sformatf("v%0d_rsp_err", vi), bus.rsp_err, v.exp_err);
                chk($sformatf("v%0d_rsp_cycle", vi), n, v.exp_cyc);
                got_r = 1'b1;
            end
            edge1();
            if (got_g || (v.drop_early && n == 0)) bus.req = '0;
            n++;
        end
        chk($sformatf("v%0d_gnt_seen", vi), got_g, 1'b1);
        chk($sformatf("v%0d_rsp_seen", vi), got_r, 1'b1);
        chk($sformatf("v%0d_operand_hold", vi), hold_ok, 1'b1);
        chk($sformatf("v%0d_busy", vi), busy_ok, 1'b1);
    endtask

    task automatic wait_gnt(input string nm, input logic [N-1:0] exp);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                seen = 1'b1;
                chk(nm, bus.gnt, exp);
            end
            n++;
        end
        chk({nm, "_seen"}, seen, 1'b1);
    endtask

    task automatic wait_rsp(input string nm, input logic [N-1:0] exp_v, input logic [2*DW-1:0] exp_c,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        int n;
        bit seen, hold;
        n = 0; seen = 1'b0; hold = 1'b1;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (bus.mul_a !== ea || bus.mul_b !== eb) hold = 1'b0;
            if (bus.rsp_valid != '0) begin
                seen = 1'b1;
                chk({nm, "_valid"}, bus.rsp_valid, exp_v);
                chk({nm, "_c"}, bus.rsp_c, exp_c);
                chk({nm, "_err"}, bus.rsp_err, 1'b0);
            end
            n++;
        end
        chk({nm, "_seen"}, seen, 1'b1);
        chk({nm, "_hold"}, hold, 1'b1);
        edge1();
    endtask

    initial begin
        logic [DW-1:0]   ta [4];
        logic [DW-1:0]   tb [4];
        logic [2*DW-1:0] tp [4];
        int              order [5];
        bit              quiet;

        tbl[0] = '{req:4'b0100, a:16'h0003, b:16'h0005, lat:2, dead:0, spur:0, drop_early:0,
                   exp_gnt:4'b0100, exp_c:32'h0000_000F, exp_err:1'b0, exp_cyc:4};
        tbl[1] = '{req:4'b0010, a:16'h1234, b:16'h0010, lat:1, dead:1, spur:0, drop_early:0,
                   exp_gnt:4'b0010, exp_c:32'h0000_0000, exp_err:1'b1, exp_cyc:9};
        tbl[2] = '{req:4'b0001, a:16'h0007, b:16'h0006, lat:1, dead:0, spur:0, drop_early:0,
                   exp_gnt:4'b0001, exp_c:32'h0000_002A, exp_err:1'b0, exp_cyc:3};
        tbl[3] = '{req:4'b1000, a:16'hFFFF, b:16'hFFFF, lat:3, dead:0, spur:1, drop_early:0,
                   exp_gnt:4'b1000, exp_c:32'hFFFE_0001, exp_err:1'b0, exp_cyc:5};
        tbl[4] = '{req:4'b0010, a:16'h00FF, b:16'h0101, lat:5, dead:0, spur:0, drop_early:0,
                   exp_gnt:4'b0010, exp_c:32'h0000_FFFF, exp_err:1'b0, exp_cyc:7};
        tbl[5] = '{req:4'b0001, a:16'h0100, b:16'h0100, lat:2, dead:0, spur:0, drop_early:1,
                   exp_gnt:4'b0001, exp_c:32'h0001_0000, exp_err:1'b0, exp_cyc:4};

        rst       = 1'b0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_gnt", bus.gnt, 4'b0000);
        chk("reset_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("reset_mul_start", bus.mul_start, 1'b0);
        chk("reset_mul_a", bus.mul_a, 16'h0000);
        chk("reset_mul_b", bus.mul_b, 16'h0000);
        chk("reset_rsp_c", bus.rsp_c, 32'h0);
        chk("reset_rsp_err", bus.rsp_err, 1'b0);
        rst = 1'b1;
        edge1();

        // Single-winner operations: plain, watchdog, recovery, extremes with
        // a spurious done in START, long latency, req dropped before gnt.
        for (int i = 0; i < 6; i++) begin
            run_vec(i, tbl[i]);
        end

        // All four requesters together right after reset.
        rst = 1'b0;
        repeat (2) edge1();
        rst = 1'b1;
        edge1();
        mul_dead = 1'b0; mul_spur = 1'b0; mul_lat = 2;
        ta = '{16'h0011, 16'h0100, 16'hABCD, 16'h7FFF};
        tb = '{16'h0002, 16'h0003, 16'h0002, 16'h7FFF};
        tp = '{32'h0000_0022, 32'h0000_0300, 32'h0001_579A, 32'h3FFF_0001};
        for (int k = 0; k < N; k++) begin
            bus.req_a[k] = ta[k];
            bus.req_b[k] = tb[k];
        end
        bus.req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_gnt($sformatf("all4_gnt%0d", k), 4'(1 << k));
            edge1();
            bus.req[k] = 1'b0;
            wait_rsp($sformatf("all4_rsp%0d", k), 4'(1 << k), tp[k], ta[k], tb[k]);
        end

        // Fairness: req[0] held, req[2] pulsed.
        bus.req_a[0] = 16'h0010; bus.req_b[0] = 16'h0010;
        bus.req_a[2] = 16'h0020; bus.req_b[2] = 16'h0003;
        order = '{0, 2, 0, 2, 0};
        bus.req = 4'b0101;
        for (int g = 0; g < 5; g++) begin
            wait_gnt($sformatf("fair_gnt%0d", g), 4'(1 << order[g]));
            edge1();
            if (order[g] == 2) bus.req[2] = 1'b0;
            else if (g == 4)   bus.req[0] = 1'b0;
            else               bus.req[2] = 1'b1;
            if (order[g] == 2)
                wait_rsp($sformatf("fair_rsp%0d", g), 4'b0100, 32'h0000_0060, 16'h0020, 16'h0003);
            else
                wait_rsp($sformatf("fair_rsp%0d", g), 4'b0001, 32'h0000_0100, 16'h0010, 16'h0010);
        end

        // Reset in the middle of WAIT with the multiplier silent.
        mul_dead = 1'b1;
        bus.req_a[2] = 16'h0055; bus.req_b[2] = 16'h0066;
        bus.req_a[0] = 16'h0004; bus.req_b[0] = 16'h0005;
        bus.req_a[3] = 16'h0009; bus.req_b[3] = 16'h0009;
        bus.req = 4'b0100;
        wait_gnt("rstw_gnt", 4'b0100);
        edge1();
        bus.req = '0;
        edge1();
        chk("rstw_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_mul_start", bus.mul_start, 1'b0);
        chk("rstw_gnt", bus.gnt, 4'b0000);
        chk("rstw_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rstw_mul_a", bus.mul_a, 16'h0000);
        chk("rstw_rsp_c", bus.rsp_c, 32'h0);
        repeat (2) edge1();
        rst = 1'b1;
        mul_dead = 1'b0; mul_lat = 1;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || busy) quiet = 1'b0;
        end
        chk("rstw_no_rsp", quiet, 1'b1);
        edge1();
        bus.req = 4'b1001;
        wait_gnt("rstw_ptr0_gnt", 4'b0001);
        edge1();
        bus.req[0] = 1'b0;
        wait_rsp("rstw_ptr0_rsp", 4'b0001, 32'h0000_0014, 16'h0004, 16'h0005);
        wait_gnt("rstw_next_gnt", 4'b1000);
        edge1();
        bus.req[3] = 1'b0;
        wait_rsp("rstw_next_rsp", 4'b1000, 32'h0000_0051, 16'h0009, 16'h0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one `BIT_WIDTH x `BIT_WIDTH multiplier (start/done handshake, 2*`BIT_WIDTH product) among NUM_REQ requesters in the HE datapath.
- Arbitration is round-robin.
- Latches the winner's operands and holds them stable for the whole multiplier operation.
- Returns the product to the winner with a one-cycle valid; a watchdog recovers from a multiplier that never asserts done.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DW, `BIT_WIDTH, operand width; product is 2*DW
- TIMEOUT, 64, max WAIT cycles before error response; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request, held until matching gnt
- req_a  in  NUM_REQ x DW  per-requester operand a
- req_b  in  NUM_REQ x DW  per-requester operand b
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
- rsp_c  out  2*DW  product, valid while any rsp_valid bit is high
- rsp_err  out  1  high with rsp_valid when the watchdog fired
- busy  out  1  high in every state except IDLE
- mul_start  out  1  start pulse to multiplier
- mul_a  out  DW  operand a to multiplier
- mul_b  out  DW  operand b to multiplier
- mul_c  in  2*DW  product from multiplier
- mul_done  in  1  multiplier done pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rr pointer=0; cur_idx=0; operand and result registers=0; watchdog count=0.
  - All outputs 0. mul_start drops immediately.
  - An in-flight operation is abandoned with no rsp_valid.
- States:
  - IDLE: if any req bit is set, pick the first set bit at or after the rr pointer (wrapping at NUM_REQ). Latch cur_idx, req_a[idx], req_b[idx]. Go to START. Otherwise stay in IDLE.
  - START (exactly 1 cycle): gnt[cur_idx]=1, mul_start=1. Go to WAIT.
  - WAIT: mul_start=0; watchdog counts up each cycle.
    - mul_done=1: capture mul_c into the result register, rsp_err<=0, go to RESP.
    - TIMEOUT!=0, count reaches TIMEOUT-1, and mul_done=0: result=0, rsp_err<=1, go to RESP.
  - RESP (exactly 1 cycle): rsp_valid[cur_idx]=1; rsp_c/rsp_err driven from registers; rr pointer=(cur_idx+1) mod NUM_REQ. Go to IDLE.
- Operand hold: mul_a/mul_b come from the latched registers and stay stable from START through RESP. They are 0 only out of reset.
- Latency: arbitration in cycle 0 -> gnt and mul_start in cycle 1 -> rsp_valid in cycle L+2, where L = cycles from mul_start to mul_done (L>=1). Next arbitration is in cycle L+3.
- Throughput: one operation per L+3 cycles. IDLE always lasts at least 1 cycle between operations, so the multiplier is back in READY before the next start.
- mul_done outside WAIT, including in the START cycle, is ignored.
- rsp_c holds its last value between responses. The bench checks it only under rsp_valid.
- Request rules:
  - A req dropped between arbitration and gnt still completes. Requesters hold req until gnt.
  - A requester whose req stays high after rsp_valid is treated as a new request.
- Fairness: the just-served requester has lowest priority next round, so no requester waits more than NUM_REQ-1 operations.
- Arithmetic: no arithmetic on data. Product width is 2*DW and is passed through unmodified. Watchdog counter width is clog2(TIMEOUT+1).

Decomposition:
- Package he_mul_arb_pkg: state enum (IDLE, START, WAIT, RESP), and a function computing the watchdog counter width.
- DW default comes from `BIT_WIDTH in he_headers.sv.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs: req vector, pointer. Outputs: one-hot grant, encoded index, any. mul_arbiter owns the pointer register.

Test Plan:
1. Single request: req[2]=1, a=0x3, b=0x5, bench multiplier L=2. Expect gnt[2] in cycle 1; rsp_valid[2] in cycle 4 with rsp_c=0xF, rsp_err=0; busy high in cycles 1-4.
2. All four requesters asserted in the same cycle after reset with distinct operands. Expect grants in order 0,1,2,3, each in its own operation. Each rsp_valid carries its own product; mul_a/mul_b stay stable through each WAIT.
3. Fairness: req[0] held high continuously, req[2] pulsed. Expect grants alternating 0,2,0,2; req[0] never granted twice while req[2] is pending.
4. Watchdog: TIMEOUT=8, multiplier never asserts done. Expect rsp_valid[idx] and rsp_err=1 with rsp_c=0 exactly 8 cycles after START. A later normal operation returns rsp_err=0.
5. Reset mid-WAIT: assert rst=0 two cycles into WAIT. Expect mul_start, busy, gnt and rsp_valid at 0 immediately, no rsp_valid after release, next grant arbitrated from pointer 0.
6. Width extremes: a=b=2^DW-1. Expect rsp_c=2^(2DW)-2^(DW+1)+1 with no truncation. A spurious mul_done pulse injected in the START cycle is ignored, and the result still arrives at L+2.
